// File: rtl/bit4_sum_accumulator.sv
// Sums FRAME adder results into a frame total with a sticky wrap flag; results visible the edge after transfer.
// Backpressure: while a total is held (out_valid high) in_ready is low until out_ready takes it.
module bit4_sum_accumulator #(
    parameter int FRAME = 10,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_sum,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [3:0]       out_count,
    output logic             overflow
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [3:0] FRAME_CNT = 4'(FRAME);

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc_nx;
    logic [3:0]       count_nx;
    logic             ovf_nx;
    logic             rdy_nx;
    logic             xfer;
    logic [ACC_W:0]   sum_ext;

    assign xfer      = in_valid && in_ready && (state == ACCUM);
    assign sum_ext   = {1'b0, out_acc} + {{(ACC_W-4){1'b0}}, in_sum};
    assign out_valid = (state == HOLD);

    always_comb begin
        state_nx = state;
        acc_nx   = out_acc;
        count_nx = out_count;
        ovf_nx   = overflow;
        rdy_nx   = in_ready;
        if (clear) begin
            // clear wins over both a sample transfer and a total handshake
            state_nx = ACCUM;
            acc_nx   = '0;
            count_nx = '0;
            ovf_nx   = 1'b0;
            rdy_nx   = 1'b1;
        end else if (state == ACCUM) begin
            rdy_nx = 1'b1;
            if (xfer) begin
                acc_nx   = sum_ext[ACC_W-1:0];
                count_nx = out_count + 4'd1;
                ovf_nx   = overflow | sum_ext[ACC_W];
                if (count_nx == FRAME_CNT) begin
                    state_nx = HOLD;
                    rdy_nx   = 1'b0;
                end
            end
        end else begin
            rdy_nx = 1'b0;
            if (out_ready) begin
                state_nx = ACCUM;
                acc_nx   = '0;
                count_nx = '0;
                ovf_nx   = 1'b0;
                rdy_nx   = 1'b1;
            end
        end
    end

    // in_ready stays low in reset and rises on the first edge afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            out_acc   <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nx;
            out_acc   <= acc_nx;
            out_count <= count_nx;
            overflow  <= ovf_nx;
            in_ready  <= rdy_nx;
        end
    end

endmodule

// File: tb/tb_bit4_sum_accumulator.sv
// Directed table-driven bench for bit4_sum_accumulator with default FRAME=10, ACC_W=8.
module tb_bit4_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_sum;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_acc;
    logic [3:0] out_count;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic       iv;
        logic [4:0] sum;
        logic       clr;
        logic       ordy;
        int         acc;
        int         cnt;
        logic       vld;
        logic       rdy;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    bit4_sum_accumulator #(.FRAME(10), .ACC_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int acc, input int cnt,
                           input int vld, input int rdy, input int ovf);
        chk({tag, ".acc"},   int'(out_acc),   acc);
        chk({tag, ".count"}, int'(out_count), cnt);
        chk({tag, ".valid"}, int'(out_valid), vld);
        chk({tag, ".ready"}, int'(in_ready),  rdy);
        chk({tag, ".ovf"},   int'(overflow),  ovf);
    endtask

    task automatic drive(input logic iv, input logic [4:0] s, input logic clr, input logic ordy);
        in_valid  = iv;
        in_sum    = s;
        clear     = clr;
        out_ready = ordy;
    endtask

    task automatic step(input logic iv, input logic [4:0] s, input logic clr, input logic ordy);
        drive(iv, s, clr, ordy);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic iv, input int s, input logic clr, input logic ordy,
                                input int acc, input int cnt, input logic vld, input logic rdy,
                                input logic ovf);
        vec_t v;
        v.iv = iv; v.sum = 5'(s); v.clr = clr; v.ordy = ordy;
        v.acc = acc; v.cnt = cnt; v.vld = vld; v.rdy = rdy; v.ovf = ovf;
        tbl.push_back(v);
    endfunction

    initial begin
        // Nominal frame: 10 x 7
        for (int k = 1; k <= 10; k++)
            add(1, 7, 0, 0, 7 * k, k, k == 10, k != 10, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0);
        // Overflow frame: 10 x 30, wraps on the 9th sample (270)
        for (int k = 1; k <= 10; k++)
            add(1, 30, 0, 0, (30 * k) % 256, k, k == 10, k != 10, (30 * k) >= 256);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0);
        // Back-pressure: frame of 10 x 1, then held 5 cycles with in_valid asserted
        for (int k = 1; k <= 10; k++)
            add(1, 1, 0, 0, k, k, k == 10, k != 10, 0);
        for (int k = 0; k < 5; k++)
            add(1, 9, 0, 0, 10, 10, 1, 0, 0);
        add(1, 9, 0, 1, 0, 0, 0, 1, 0);
        add(1, 9, 0, 0, 9, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0);
        // Clear mid-frame drops the simultaneous sample
        for (int k = 1; k <= 3; k++)
            add(1, 5, 0, 0, 5 * k, k, 0, 1, 0);
        add(1, 12, 1, 0, 0, 0, 0, 1, 0);
        add(1, 12, 0, 0, 12, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0);
        // Clear after wrap resets the sticky flag
        for (int k = 1; k <= 9; k++)
            add(1, 30, 0, 0, (30 * k) % 256, k, 0, 1, (30 * k) >= 256);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0);

        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_pre_edge.ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        chk_all("rel_edge", 0, 0, 0, 1, 0);

        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].sum, tbl[i].clr, tbl[i].ordy);
            chk_all($sformatf("vec%0d", i), tbl[i].acc, tbl[i].cnt,
                    int'(tbl[i].vld), int'(tbl[i].rdy), int'(tbl[i].ovf));
        end

        // Clear in HOLD together with out_ready
        for (int k = 1; k <= 10; k++)
            step(1, 2, 0, 0);
        chk_all("hold_clr.pre", 20, 10, 1, 0, 0);
        step(0, 0, 1, 1);
        chk_all("hold_clr.post", 0, 0, 0, 1, 0);
        step(1, 3, 0, 0);
        chk_all("hold_clr.next", 3, 1, 0, 1, 0);

        // Asynchronous reset mid-frame, sample offered across the release edge
        for (int k = 2; k <= 4; k++)
            step(1, 6, 0, 0);
        chk_all("mid.pre", 3 + 18, 4, 0, 1, 0);
        drive(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 5, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("rst_rel_noaccept", 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        chk_all("rst_rel_accept", 5, 1, 0, 1, 0);
        drive(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
